// File: rtl/ram_1port_bist_if.sv
// Control, status and RAM-observation signals of the RAM self-test block.
// The master side requests runs and watches results; the slave side is the sequencer.
interface ram_1port_bist_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              start;
    logic [DATA_W-1:0] seed;
    logic              pat_sel;
    logic              err_inj;
    logic              busy;
    logic              done;
    logic              pass;
    logic [15:0]       err_cnt;
    logic [ADDR_W-1:0] first_err_addr;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output start, seed, pat_sel, err_inj,
        input  busy, done, pass, err_cnt, first_err_addr,
        input  ram_en, ram_we, ram_addr, ram_wdata, ram_rdata
    );

    modport slave (
        input  start, seed, pat_sel, err_inj,
        output busy, done, pass, err_cnt, first_err_addr,
        output ram_en, ram_we, ram_addr, ram_wdata, ram_rdata
    );
endinterface

// File: rtl/ram_1port_bist.sv
// Single-port RAM with a write/readback/compare sequencer; a run takes 2*DEPTH+RD_LAT+1 cycles from start to done.
// No backpressure: start is accepted only in IDLE or DONE and ignored while busy.
module ram_1port_bist #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int OUT_REG  = 0,
    parameter int INJ_ADDR = 3
) (
    input  logic             sys_clk,
    input  logic             rst,
    ram_1port_bist_if.slave  bus
);
    localparam int DEPTH  = 2**ADDR_W;
    localparam int RD_LAT = 1 + OUT_REG;

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] seed_q;
    logic              pat_q;
    logic              inj_q;
    logic [1:0]        drain_cnt;
    logic [RD_LAT-1:0] vld_pipe;
    logic [DATA_W-1:0] exp_pipe  [RD_LAT];
    logic [ADDR_W-1:0] addr_pipe [RD_LAT];
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] s,
                                                  input logic              inv);
        logic [DATA_W-1:0] w;
        w = DATA_W'(a) + s;
        return inv ? ~w : w;
    endfunction

    logic [ADDR_W-1:0] addr_nxt;
    logic              last_addr;
    logic [DATA_W-1:0] wdata_first;
    logic [DATA_W-1:0] wdata_nxt;
    logic              mism;
    logic [15:0]       err_cnt_nxt;

    assign addr_nxt    = bus.ram_addr + ADDR_W'(1);
    assign last_addr   = &bus.ram_addr;
    assign wdata_first = pattern('0, bus.seed, bus.pat_sel)
                       ^ DATA_W'(bus.err_inj && (INJ_ADDR == 0));
    assign wdata_nxt   = pattern(addr_nxt, seed_q, pat_q)
                       ^ DATA_W'(inj_q && (addr_nxt == ADDR_W'(INJ_ADDR)));
    assign mism        = vld_pipe[RD_LAT-1] && (bus.ram_rdata != exp_pipe[RD_LAT-1]);

    always_comb begin
        err_cnt_nxt = bus.err_cnt;
        if (mism && (bus.err_cnt != 16'hFFFF))
            err_cnt_nxt = bus.err_cnt + 16'd1;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state              <= IDLE;
            seed_q             <= '0;
            pat_q              <= 1'b0;
            inj_q              <= 1'b0;
            drain_cnt          <= '0;
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
            bus.pass           <= 1'b0;
            bus.err_cnt        <= '0;
            bus.first_err_addr <= '0;
            bus.ram_en         <= 1'b0;
            bus.ram_we         <= 1'b0;
            bus.ram_addr       <= '0;
            bus.ram_wdata      <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state         <= WRITE;
                        seed_q        <= bus.seed;
                        pat_q         <= bus.pat_sel;
                        inj_q         <= bus.err_inj;
                        bus.busy      <= 1'b1;
                        bus.pass      <= 1'b0;
                        bus.ram_en    <= 1'b1;
                        bus.ram_we    <= 1'b1;
                        bus.ram_addr  <= '0;
                        bus.ram_wdata <= wdata_first;
                    end
                end
                WRITE: begin
                    if (last_addr) begin
                        state        <= READ;
                        bus.ram_we   <= 1'b0;
                        bus.ram_addr <= '0;
                    end else begin
                        bus.ram_addr  <= addr_nxt;
                        bus.ram_wdata <= wdata_nxt;
                    end
                end
                READ: begin
                    if (last_addr) begin
                        state      <= DRAIN;
                        bus.ram_en <= 1'b0;
                        drain_cnt  <= 2'(RD_LAT - 1);
                    end else begin
                        bus.ram_addr <= addr_nxt;
                    end
                end
                DRAIN: begin
                    // The last compare lands on this same edge, so pass looks at the next count.
                    if (drain_cnt == 2'd0) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.pass <= (err_cnt_nxt == 16'd0);
                    end else begin
                        drain_cnt <= drain_cnt - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (bus.start && (state == IDLE || state == DONE)) begin
                bus.err_cnt        <= '0;
                bus.first_err_addr <= '0;
            end else begin
                bus.err_cnt <= err_cnt_nxt;
                if (mism && (bus.err_cnt == 16'd0))
                    bus.first_err_addr <= addr_pipe[RD_LAT-1];
            end
        end
    end

    // Expected word and its address ride alongside the RAM read path.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= bus.ram_en & ~bus.ram_we;
            for (int i = 1; i < RD_LAT; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    always_ff @(posedge sys_clk) begin
        exp_pipe[0]  <= pattern(bus.ram_addr, seed_q, pat_q);
        addr_pipe[0] <= bus.ram_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            exp_pipe[i]  <= exp_pipe[i-1];
            addr_pipe[i] <= addr_pipe[i-1];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (bus.ram_en && bus.ram_we)
            mem[bus.ram_addr] <= bus.ram_wdata;
    end

    // Read-first: an enabled write cycle also returns the old contents.
    always_ff @(posedge sys_clk) begin
        if (rst)
            rd_q <= '0;
        else if (bus.ram_en)
            rd_q <= mem[bus.ram_addr];
    end

    if (OUT_REG != 0) begin : g_oreg
        logic              en_q;
        logic [DATA_W-1:0] rd_o;
        always_ff @(posedge sys_clk) begin
            if (rst) begin
                en_q <= 1'b0;
                rd_o <= '0;
            end else begin
                en_q <= bus.ram_en;
                if (en_q)
                    rd_o <= rd_q;
            end
        end
        assign bus.ram_rdata = rd_o;
    end else begin : g_noreg
        assign bus.ram_rdata = rd_q;
    end
endmodule

// File: tb/tb_ram_1port_bist.sv
// Bench for ram_1port_bist: an 8x32 single-cycle instance and a 12x16 registered-output instance,
// checked cycle by cycle against an arithmetic model of the write/read/compare run.
module tb_ram_1port_bist;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic start_c = 1'b0;
    int   seed_c = 0;
    logic pat_c = 1'b0;
    logic inj_c = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int tr_bad  = 0;

    always #5 clk = ~clk;

    ram_1port_bist_if #(.DATA_W(8),  .ADDR_W(5)) if0 ();
    ram_1port_bist_if #(.DATA_W(12), .ADDR_W(4)) if1 ();

    assign if0.start   = start_c && !sel;
    assign if0.seed    = seed_c[7:0];
    assign if0.pat_sel = pat_c;
    assign if0.err_inj = inj_c;
    assign if1.start   = start_c && sel;
    assign if1.seed    = seed_c[11:0];
    assign if1.pat_sel = pat_c;
    assign if1.err_inj = inj_c;

    ram_1port_bist #(.DATA_W(8), .ADDR_W(5), .OUT_REG(0), .INJ_ADDR(3)) dut0 (
        .sys_clk(clk), .rst(rst), .bus(if0.slave));
    ram_1port_bist #(.DATA_W(12), .ADDR_W(4), .OUT_REG(1), .INJ_ADDR(3)) dut1 (
        .sys_clk(clk), .rst(rst), .bus(if1.slave));

    int m_busy, m_done, m_pass, m_err, m_first, m_en, m_we, m_addr, m_wdata, m_rdata;
    always_comb begin
        if (sel) begin
            m_busy = 32'(if1.busy);       m_done = 32'(if1.done);    m_pass = 32'(if1.pass);
            m_err = 32'(if1.err_cnt);     m_first = 32'(if1.first_err_addr);
            m_en = 32'(if1.ram_en);       m_we = 32'(if1.ram_we);    m_addr = 32'(if1.ram_addr);
            m_wdata = 32'(if1.ram_wdata); m_rdata = 32'(if1.ram_rdata);
        end else begin
            m_busy = 32'(if0.busy);       m_done = 32'(if0.done);    m_pass = 32'(if0.pass);
            m_err = 32'(if0.err_cnt);     m_first = 32'(if0.first_err_addr);
            m_en = 32'(if0.ram_en);       m_we = 32'(if0.ram_we);    m_addr = 32'(if0.ram_addr);
            m_wdata = 32'(if0.ram_wdata); m_rdata = 32'(if0.ram_rdata);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tr(input string nm, input int c, input int act, input int exp);
        if (act !== exp) begin
            if (tr_bad == 0)
                $display("  trace detail: %s at cycle %0d got 0x%0h want 0x%0h", nm, c, act, exp);
            tr_bad++;
        end
    endtask

    // Reference: the word for an address is addr+seed mod 2^W, optionally inverted.
    function automatic int word(input int s, input int a, input int sd, input int p);
        int mask, v;
        mask = (s != 0) ? 'hFFF : 'hFF;
        v = (a + sd) & mask;
        if (p != 0) v = ~v & mask;
        return v;
    endfunction

    function automatic int stored(input int s, input int a, input int sd, input int p, input int inj);
        return word(s, a, sd, p) ^ (((inj != 0) && (a == 3)) ? 1 : 0);
    endfunction

    task automatic chk_reset(input string nm);
        chk({nm, " busy"}, m_busy, 0);   chk({nm, " done"}, m_done, 0);
        chk({nm, " pass"}, m_pass, 0);   chk({nm, " err_cnt"}, m_err, 0);
        chk({nm, " first"}, m_first, 0); chk({nm, " ram_en"}, m_en, 0);
        chk({nm, " ram_we"}, m_we, 0);   chk({nm, " ram_addr"}, m_addr, 0);
        chk({nm, " wdata"}, m_wdata, 0); chk({nm, " rdata"}, m_rdata, 0);
    endtask

    // One full run. pre: start is already high for the coming edge. chain: leave start
    // high in the done cycle so the next call begins back-to-back.
    task automatic run(input int s, input int sd, input int p, input int inj, input bit pre,
                       input int noise_c, input bit chain,
                       output int o_pass, output int o_err, output int o_first,
                       output int w_last, output int r3);
        int d, rl, c, tdone, lim, exp_err, exp_first, ra;
        d  = (s != 0) ? 16 : 32;
        rl = (s != 0) ? 2 : 1;
        lim = 2 * d + rl + 8;
        exp_err = 0; exp_first = 0; w_last = -1; r3 = -1;
        for (int a = 0; a < d; a++)
            if (stored(s, a, sd, p, inj) != word(s, a, sd, p)) begin
                if (exp_err == 0) exp_first = a;
                exp_err++;
            end
        sel = s[0]; seed_c = sd; pat_c = p[0]; inj_c = inj[0];
        if (!pre) begin
            @(negedge clk);
            start_c = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        start_c = 1'b0;
        tr_bad = 0; tdone = 0; c = 1;
        while (tdone == 0 && c <= lim) begin
            start_c = (c == noise_c);
            if (c <= d) begin
                tr("wr en", c, m_en, 1); tr("wr we", c, m_we, 1);
                tr("wr addr", c, m_addr, c - 1);
                tr("wr data", c, m_wdata, stored(s, c - 1, sd, p, inj));
                if (c == d) w_last = m_wdata;
            end else if (c <= 2 * d) begin
                tr("rd en", c, m_en, 1); tr("rd we", c, m_we, 0);
                tr("rd addr", c, m_addr, c - d - 1);
            end else if (c <= 2 * d + rl) begin
                tr("drain en", c, m_en, 0);
            end
            ra = c - d - 1 - rl;
            if (ra >= 0 && ra < d) begin
                tr("rdata", c, m_rdata, stored(s, ra, sd, p, inj));
                if (ra == 3) r3 = m_rdata;
            end
            tr("busy", c, m_busy, (c <= 2 * d + rl) ? 1 : 0);
            tr("done", c, m_done, (c == 2 * d + rl + 1) ? 1 : 0);
            if (m_done == 1) begin
                tdone = c;
            end else begin
                @(negedge clk);
                c++;
            end
        end
        start_c = 1'b0;
        chk("ram/status trace", tr_bad, 0);
        chk("done cycle", tdone, 2 * d + rl + 1);
        o_pass = m_pass; o_err = m_err; o_first = m_first;
        chk("model err_cnt", m_err, exp_err);
        chk("model first_err_addr", m_first, exp_first);
        chk("model pass", m_pass, (exp_err == 0) ? 1 : 0);
        if (chain) begin
            start_c = 1'b1;
        end else begin
            @(negedge clk);
            chk("done one-cycle", m_done, 0);
            chk("pass holds", m_pass, (exp_err == 0) ? 1 : 0);
            chk("idle after done", m_busy, 0);
        end
    endtask

    typedef struct {
        int s; int sd; int p; int inj;
        int e_pass; int e_err; int e_first;
    } vec_t;

    initial begin
        vec_t tbl [5];
        int rp, re, rf, wl, r3, s, d;
        tbl[0] = '{0, 'h00,  0, 0, 1, 0, 0};
        tbl[1] = '{0, 'hF0,  1, 0, 1, 0, 0};
        tbl[2] = '{0, 'h00,  0, 1, 0, 1, 3};
        tbl[3] = '{1, 'h000, 0, 0, 1, 0, 0};
        tbl[4] = '{1, 'hFFA, 0, 1, 0, 1, 3};

        repeat (3) @(negedge clk);
        sel = 1'b0; chk_reset("reset dut0");
        sel = 1'b1; chk_reset("reset dut1");
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run(tbl[i].s, tbl[i].sd, tbl[i].p, tbl[i].inj, 1'b0, 0, 1'b0, rp, re, rf, wl, r3);
            chk("table pass", rp, tbl[i].e_pass);
            chk("table err_cnt", re, tbl[i].e_err);
            chk("table first_err_addr", rf, tbl[i].e_first);
            if (i == 1) chk("wdata at addr 31", wl, 'hF0);
            if (i == 2) chk("rdata of injected addr 3", r3, 'h02);
        end

        // Reset during the 10th write cycle.
        sel = 1'b0; seed_c = 7; pat_c = 1'b0; inj_c = 1'b0;
        @(negedge clk);
        start_c = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_c = 1'b0;
        repeat (9) @(negedge clk);
        chk("busy before mid-run rst", m_busy, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset("mid-run rst");
        start_c = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_c = 1'b0;
        chk("rst beats start", m_busy, 0);
        rst = 1'b0;
        run(0, 7, 0, 0, 1'b0, 0, 1'b0, rp, re, rf, wl, r3);
        chk("pass after mid-run rst", rp, 1);

        // Start pulse during READ is ignored.
        run(0, 'h33, 1, 0, 1'b0, 37, 1'b0, rp, re, rf, wl, r3);
        chk("pass with start in READ", rp, 1);

        // Back-to-back: start in the DONE cycle, second done exactly one run later.
        run(1, 'h123, 0, 1, 1'b0, 0, 1'b1, rp, re, rf, wl, r3);
        run(1, 'h456, 1, 0, 1'b1, 0, 1'b0, rp, re, rf, wl, r3);
        chk("b2b second pass", rp, 1);

        for (int k = 0; k < 6; k++) begin
            s = $urandom_range(0, 1);
            d = (s != 0) ? 16 : 32;
            run(s, $urandom_range(0, 4095), $urandom_range(0, 1), $urandom_range(0, 1),
                1'b0, $urandom_range(2, 2 * d), 1'b0, rp, re, rf, wl, r3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule
